arm_hazard_interlock: RTL and testbench

- Producer side of the decode-stage forwarding interface.
- Owns the EX and MEM destination-register pipeline slots, which carry rd write-enable, rd number, ALU/MAC select and the mem-address flag that the forwarding selector consumes.
- Generates the decode stall and bubble insertion for hazards that forwarding cannot cover: load-use and a multi-cycle MAC.
- Sits between decode and the ID/EX pipeline register in the ARM pipeline.

---
 rtl/arm_hazard_pkg.sv | 24 ++
 rtl/arm_src_match.sv | 24 ++
 rtl/arm_hazard_interlock.sv | 147 ++++++++++++++
 tb/tb_arm_hazard_interlock.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_hazard_pkg.sv
// Shared types for the decode-stage hazard interlock: destination-slot layout,
// the bubble constant and the interlock FSM states.
package arm_hazard_pkg;

  typedef struct packed {
    logic       rd_we;
    logic [3:0] rd_num;
    logic       alu_or_mac;
    logic       is_alu_for_mem_addr;
  } dest_slot_t;

  localparam dest_slot_t BUBBLE_SLOT = '{
    rd_we:               1'b0,
    rd_num:              4'd0,
    alu_or_mac:          1'b1,
    is_alu_for_mem_addr: 1'b0
  };

  typedef enum logic {
    S_RUN = 1'b0,
    S_MAC = 1'b1
  } hz_state_t;

endpackage

// File: rtl/arm_src_match.sv
// Masked N-way compare of decode source registers against one destination
// register number; hit_o is set when any enabled slot matches.
module arm_src_match #(
  parameter int NUM_SRC = 3
) (
  input  logic [4*NUM_SRC-1:0] src_num_i,
  input  logic [NUM_SRC-1:0]   src_mask_i,
  input  logic [3:0]           ref_num_i,
  output logic                 hit_o
);

  // OR-reduce the per-slot masked equality terms
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_mask_i[i] && (src_num_i[4*i +: 4] == ref_num_i)) begin
        hit_o = 1'b1;
      end else begin
        hit_o = hit_o;
      end
    end
  end

endmodule

// File: rtl/arm_hazard_interlock.sv
// Owns the EX/MEM destination slots feeding forwarding and raises the decode
// stall for load-use and multi-cycle MAC hazards that forwarding cannot cover.
module arm_hazard_interlock
  import arm_hazard_pkg::*;
#(
  parameter int MAC_CYCLES = 3,
  parameter int NUM_SRC    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_rd_we,
  input  logic [3:0]           id_rd_num,
  input  logic                 id_alu_or_mac,
  input  logic                 id_is_alu_for_mem_addr,
  input  logic [4*NUM_SRC-1:0] id_src_num,
  input  logic [NUM_SRC-1:0]   id_src_mask,
  input  logic                 flush,
  output logic                 stall_id,
  output logic                 mac_busy,
  output logic                 ex_rd_we,
  output logic [3:0]           ex_rd_num,
  output logic                 ex_alu_or_mac,
  output logic                 ex_is_alu_for_mem_addr,
  output logic                 mem_rd_we,
  output logic [3:0]           mem_rd_num
);

  localparam int CW = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MAC_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          MAC_HOLD = (MAC_CYCLES > 1) ? 1'b1 : 1'b0;

  hz_state_t     state_q;
  logic [CW-1:0] cnt_q;
  dest_slot_t    ex_q;
  dest_slot_t    ex_d;
  logic          mem_rd_we_q;
  logic [3:0]    mem_rd_num_q;

  logic       ex_is_load_s;
  logic       src_hit_s;
  logic       load_use_s;
  logic       ex_kill_s;
  logic       mac_enter_s;
  dest_slot_t id_slot_s;
  logic       stall_s;

  assign ex_is_load_s = ex_q.rd_we & ex_q.alu_or_mac & ex_q.is_alu_for_mem_addr;

  arm_src_match #(
    .NUM_SRC (NUM_SRC)
  ) u_load_use_match (
    .src_num_i  (id_src_num),
    .src_mask_i (id_src_mask),
    .ref_num_i  (ex_q.rd_num),
    .hit_o      (src_hit_s)
  );

  assign load_use_s = id_valid & ex_is_load_s & src_hit_s;

  assign id_slot_s = '{
    rd_we:               id_rd_we,
    rd_num:              id_rd_num,
    alu_or_mac:          id_alu_or_mac,
    is_alu_for_mem_addr: id_is_alu_for_mem_addr
  };

  // Next EX contents while running; flush takes priority over load-use
  always_comb begin
    ex_kill_s   = flush | load_use_s | ~id_valid;
    ex_d        = BUBBLE_SLOT;
    mac_enter_s = 1'b0;
    if (ex_kill_s) begin
      ex_d        = BUBBLE_SLOT;
      mac_enter_s = 1'b0;
    end else begin
      ex_d        = id_slot_s;
      mac_enter_s = ~id_alu_or_mac & MAC_HOLD;
    end
  end

  // Decode stall: load-use while running, unconditional while a MAC holds EX
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      S_RUN:   stall_s = load_use_s & ~flush;
      S_MAC:   stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  // Interlock FSM together with the EX/MEM slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      ex_q         <= BUBBLE_SLOT;
      mem_rd_we_q  <= 1'b0;
      mem_rd_num_q <= 4'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          mem_rd_we_q  <= ex_q.rd_we;
          mem_rd_num_q <= ex_q.rd_num;
          ex_q         <= ex_d;
          if (mac_enter_s) begin
            state_q <= S_MAC;
            cnt_q   <= CNT_LOAD;
          end else begin
            state_q <= S_RUN;
            cnt_q   <= cnt_q;
          end
        end
        S_MAC: begin
          // EX keeps the MAC; MEM sees bubbles until it leaves
          ex_q         <= ex_q;
          mem_rd_we_q  <= 1'b0;
          mem_rd_num_q <= 4'd0;
          cnt_q        <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_RUN;
          end else begin
            state_q <= S_MAC;
          end
        end
        default: begin
          state_q      <= S_RUN;
          cnt_q        <= '0;
          ex_q         <= BUBBLE_SLOT;
          mem_rd_we_q  <= 1'b0;
          mem_rd_num_q <= 4'd0;
        end
      endcase
    end
  end

  assign stall_id               = stall_s;
  assign mac_busy               = (state_q == S_MAC);
  assign ex_rd_we               = ex_q.rd_we;
  assign ex_rd_num              = ex_q.rd_num;
  assign ex_alu_or_mac          = ex_q.alu_or_mac;
  assign ex_is_alu_for_mem_addr = ex_q.is_alu_for_mem_addr;
  assign mem_rd_we              = mem_rd_we_q;
  assign mem_rd_num             = mem_rd_num_q;

endmodule

// File: tb/tb_arm_hazard_interlock.sv
// Directed and randomized check of arm_hazard_interlock against a cycle-level
// reference model that tracks pipeline slot contents and remaining EX occupancy.
module tb_arm_hazard_interlock;

  localparam int MAC_CYCLES = 3;
  localparam int NUM_SRC    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 id_valid;
  logic                 id_rd_we;
  logic [3:0]           id_rd_num;
  logic                 id_alu_or_mac;
  logic                 id_is_alu_for_mem_addr;
  logic [4*NUM_SRC-1:0] id_src_num;
  logic [NUM_SRC-1:0]   id_src_mask;
  logic                 flush;
  logic                 stall_id;
  logic                 mac_busy;
  logic                 ex_rd_we;
  logic [3:0]           ex_rd_num;
  logic                 ex_alu_or_mac;
  logic                 ex_is_alu_for_mem_addr;
  logic                 mem_rd_we;
  logic [3:0]           mem_rd_num;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic       m_ex_we, m_ex_alu, m_ex_ma;
  logic [3:0] m_ex_rd;
  logic       m_mem_we;
  logic [3:0] m_mem_rd;
  int         m_busy_left;

  arm_hazard_interlock #(
    .MAC_CYCLES (MAC_CYCLES),
    .NUM_SRC    (NUM_SRC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .id_valid               (id_valid),
    .id_rd_we               (id_rd_we),
    .id_rd_num              (id_rd_num),
    .id_alu_or_mac          (id_alu_or_mac),
    .id_is_alu_for_mem_addr (id_is_alu_for_mem_addr),
    .id_src_num             (id_src_num),
    .id_src_mask            (id_src_mask),
    .flush                  (flush),
    .stall_id               (stall_id),
    .mac_busy               (mac_busy),
    .ex_rd_we               (ex_rd_we),
    .ex_rd_num              (ex_rd_num),
    .ex_alu_or_mac          (ex_alu_or_mac),
    .ex_is_alu_for_mem_addr (ex_is_alu_for_mem_addr),
    .mem_rd_we              (mem_rd_we),
    .mem_rd_num             (mem_rd_num)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] rd,
                       input logic alu, input logic ma, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [2:0] mask, input logic fl);
    id_valid               = v;
    id_rd_we               = we;
    id_rd_num              = rd;
    id_alu_or_mac          = alu;
    id_is_alu_for_mem_addr = ma;
    id_src_num             = {s2, s1, s0};
    id_src_mask            = mask;
    flush                  = fl;
  endtask

  task automatic model_reset();
    m_ex_we = 1'b0; m_ex_rd = 4'd0; m_ex_alu = 1'b1; m_ex_ma = 1'b0;
    m_mem_we = 1'b0; m_mem_rd = 4'd0; m_busy_left = 0;
  endtask

  // Does the decode instruction read the register a load in EX is fetching?
  function automatic logic model_load_use();
    logic hit;
    hit = 1'b0;
    if (id_valid && m_ex_we && m_ex_alu && m_ex_ma)
      for (int i = 0; i < NUM_SRC; i++)
        if (id_src_mask[i] && id_src_num[4*i +: 4] == m_ex_rd) hit = 1'b1;
    return hit;
  endfunction

  task automatic check_all(input string tag);
    logic exp_stall;
    exp_stall = (m_busy_left > 0) ? 1'b1 : (model_load_use() & ~flush);
    chk({tag, "_stall"},    {3'd0, stall_id},  {3'd0, exp_stall});
    chk({tag, "_busy"},     {3'd0, mac_busy},  {3'd0, (m_busy_left > 0)});
    chk({tag, "_ex_we"},    {3'd0, ex_rd_we},  {3'd0, m_ex_we});
    chk({tag, "_ex_rd"},    ex_rd_num,         m_ex_rd);
    chk({tag, "_ex_alu"},   {3'd0, ex_alu_or_mac}, {3'd0, m_ex_alu});
    chk({tag, "_ex_ma"},    {3'd0, ex_is_alu_for_mem_addr}, {3'd0, m_ex_ma});
    chk({tag, "_mem_we"},   {3'd0, mem_rd_we}, {3'd0, m_mem_we});
    chk({tag, "_mem_rd"},   mem_rd_num,        m_mem_rd);
  endtask

  // Check current cycle, then advance one clock and update the model
  task automatic tick(input string tag);
    logic kill;
    #1;
    check_all(tag);
    @(posedge clk);
    if (m_busy_left > 0) begin
      m_mem_we = 1'b0; m_mem_rd = 4'd0;
      m_busy_left--;
    end else begin
      kill = flush | model_load_use() | ~id_valid;
      m_mem_we = m_ex_we; m_mem_rd = m_ex_rd;
      if (kill) begin
        m_ex_we = 1'b0; m_ex_rd = 4'd0; m_ex_alu = 1'b1; m_ex_ma = 1'b0;
      end else begin
        m_ex_we = id_rd_we; m_ex_rd = id_rd_num;
        m_ex_alu = id_alu_or_mac; m_ex_ma = id_is_alu_for_mem_addr;
        if (!id_alu_or_mac) m_busy_left = MAC_CYCLES - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse_check(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_stall"},  {3'd0, stall_id},  4'd0);
    chk({tag, "_busy"},   {3'd0, mac_busy},  4'd0);
    chk({tag, "_ex_we"},  {3'd0, ex_rd_we},  4'd0);
    chk({tag, "_ex_rd"},  ex_rd_num,         4'd0);
    chk({tag, "_ex_alu"}, {3'd0, ex_alu_or_mac}, 4'd1);
    chk({tag, "_ex_ma"},  {3'd0, ex_is_alu_for_mem_addr}, 4'd0);
    chk({tag, "_mem_we"}, {3'd0, mem_rd_we}, 4'd0);
    chk({tag, "_mem_rd"}, mem_rd_num,        4'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick("idle");

    // Reset mid-stream with ex_rd_num=5, no clock edge needed
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 3'b011, 1'b0);
    tick("add5");
    drive(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 3'b011, 1'b0);
    #1;
    chk("pre_rst_ex_rd", ex_rd_num, 4'd5);
    reset_pulse_check("rst_mid");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    tick("post_rst");

    // LDR r3; ADD r4,r3,r1 -> one stall cycle, then forward from MEM
    drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 1'b0);
    tick("ldr3");
    drive(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd1, 4'd0, 3'b011, 1'b0);
    #1;
    chk("lu_stall", {3'd0, stall_id}, 4'd1);
    tick("lu_c0");
    #1;
    chk("lu_ex_bubble", {3'd0, ex_rd_we}, 4'd0);
    chk("lu_mem_we",    {3'd0, mem_rd_we}, 4'd1);
    chk("lu_mem_rd",    mem_rd_num, 4'd3);
    chk("lu_unstall",   {3'd0, stall_id}, 4'd0);
    tick("lu_c1");
    #1;
    chk("lu_add_in_ex", ex_rd_num, 4'd4);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    tick("lu_drain");

    // LDR r3; ADD r4,r1,r3 with only slot0 read -> no stall
    drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 1'b0);
    tick("ldr3b");
    drive(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 4'd1, 4'd3, 4'd0, 3'b001, 1'b0);
    #1;
    chk("mask_nostall", {3'd0, stall_id}, 4'd0);
    tick("mask_c0");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    tick("mask_d0");
    tick("mask_d1");

    // MAC r7 holds EX for MAC_CYCLES-1 stall cycles
    drive(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 3'b011, 1'b0);
    tick("mac_in");
    drive(1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0);
    for (int c = 0; c < MAC_CYCLES - 1; c++) begin
      #1;
      chk("mac_busy",    {3'd0, mac_busy}, 4'd1);
      chk("mac_stall",   {3'd0, stall_id}, 4'd1);
      chk("mac_ex_rd",   ex_rd_num, 4'd7);
      chk("mac_ex_alu",  {3'd0, ex_alu_or_mac}, 4'd0);
      chk("mac_mem_we",  {3'd0, mem_rd_we}, 4'd0);
      tick("mac_hold");
    end
    #1;
    chk("mac_done_busy",  {3'd0, mac_busy}, 4'd0);
    chk("mac_done_stall", {3'd0, stall_id}, 4'd0);
    tick("mac_run");
    #1;
    chk("mac_to_mem", mem_rd_num, 4'd7);
    tick("mac_next");

    // Load-use together with flush: flush wins
    drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 1'b0);
    tick("ldr3c");
    drive(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 3'b001, 1'b1);
    #1;
    chk("fl_nostall", {3'd0, stall_id}, 4'd0);
    tick("fl_c0");
    #1;
    chk("fl_ex_bubble", {3'd0, ex_rd_we}, 4'd0);
    chk("fl_mem_rd",    mem_rd_num, 4'd3);
    chk("fl_mem_we",    {3'd0, mem_rd_we}, 4'd1);

    // ADD r2 then 3 idle cycles: MEM shows r2 for exactly one cycle
    drive(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0);
    tick("add2");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    tick("idle0");
    #1;
    chk("drain_mem2", mem_rd_num, 4'd2);
    tick("idle1");
    #1;
    chk("drain_mem0", mem_rd_num, 4'd0);
    chk("drain_ex0",  {3'd0, ex_rd_we}, 4'd0);
    tick("idle2");

    // Reset while a MAC is holding EX
    drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    tick("mac2_in");
    #1;
    chk("mac2_busy", {3'd0, mac_busy}, 4'd1);
    reset_pulse_check("rst_mac");
    tick("rst_mac_after");

    // Randomized traffic with small register space to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse_check("rnd_rst");
      end
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 5) != 0), 1'($urandom),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            3'($urandom), ($urandom_range(0, 7) == 0));
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
